// File: rtl/reset_sequencer.sv
// reset_sequencer: staged reset-release controller.
// Holds all resets while any reset source is active, then releases the
// peripheral, memory and CPU resets in order, waiting on the memory
// initialiser between the last two. Records the cause of the last reset.
// Optional feature macro: WATCHDOG_EN (adds a RUN-state watchdog that
// raises a reset source when it is not kicked within WDT_CYCLES).
module reset_sequencer #(
    parameter int HOLD_CYCLES  = 16,
    parameter int STAGE_CYCLES = 8,
    parameter int MEM_TIMEOUT  = 1024,
    parameter int WDT_CYCLES   = 1048576
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       por_reset,
    input  logic       ext_reset,
    input  logic       sw_reset_req,
    input  logic       mem_init_done,
    input  logic       wdt_kick,
    output logic       periph_reset,
    output logic       mem_reset,
    output logic       cpu_resetn,
    output logic       sys_ready,
    output logic [3:0] reset_cause,
    output logic       mem_timeout
);

    // One counter is shared by HOLD, PERIPH and MEM, so it is sized for
    // the largest of the three intervals.
    localparam int MAX_HS  = (HOLD_CYCLES > STAGE_CYCLES) ? HOLD_CYCLES : STAGE_CYCLES;
    localparam int CNT_MAX = (MAX_HS > MEM_TIMEOUT) ? MAX_HS : MEM_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGE_LOAD = CNT_W'(STAGE_CYCLES - 1);
    localparam logic [CNT_W-1:0] MEM_LOAD   = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    localparam logic [2:0] ST_HOLD   = 3'd0;
    localparam logic [2:0] ST_PERIPH = 3'd1;
    localparam logic [2:0] ST_MEM    = 3'd2;
    localparam logic [2:0] ST_CPU    = 3'd3;
    localparam logic [2:0] ST_RUN    = 3'd4;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             wdt_expire;
    logic [3:0]       src_bits;
    logic             src;

`ifdef WATCHDOG_EN
    localparam int               WDT_W    = $clog2(WDT_CYCLES);
    localparam logic [WDT_W-1:0] WDT_LOAD = WDT_W'(WDT_CYCLES - 1);
    localparam logic [WDT_W-1:0] WDT_ONE  = WDT_W'(1);

    logic [WDT_W-1:0] wdt_cnt;
    logic             wdt_pulse;

    // Watchdog interval counter: runs only in RUN, reloads on kick, and
    // emits a one-cycle pulse after counting down to zero unkicked.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wdt_cnt   <= WDT_LOAD;
            wdt_pulse <= 1'b0;
        end else if (state != ST_RUN) begin
            wdt_cnt   <= WDT_LOAD;
            wdt_pulse <= 1'b0;
        end else if (wdt_kick) begin
            wdt_cnt   <= WDT_LOAD;
            wdt_pulse <= 1'b0;
        end else if (wdt_cnt == '0) begin
            wdt_cnt   <= WDT_LOAD;
            wdt_pulse <= 1'b1;
        end else begin
            wdt_cnt   <= wdt_cnt - WDT_ONE;
            wdt_pulse <= 1'b0;
        end
    end

    // A pulse left over as the sequencer drops out of RUN for another
    // reason must not count as a second, watchdog-caused reset.
    assign wdt_expire = wdt_pulse & (state == ST_RUN);
`else
    logic unused_wdt;

    assign wdt_expire = 1'b0;
    assign unused_wdt = ^{wdt_kick, (WDT_CYCLES > 0)};
`endif

    assign src_bits = {wdt_expire, sw_reset_req, ext_reset, por_reset};
    assign src      = |src_bits;

    // Sequencer FSM with registered reset outputs, cause log and timeout flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_HOLD;
            cnt          <= HOLD_LOAD;
            periph_reset <= 1'b1;
            mem_reset    <= 1'b1;
            cpu_resetn   <= 1'b0;
            sys_ready    <= 1'b0;
            reset_cause  <= 4'b0001;
            mem_timeout  <= 1'b0;
        end else if (state == ST_HOLD) begin
            // Accumulate every source seen during the hold window.
            reset_cause <= reset_cause | src_bits;
            if (src) begin
                cnt <= HOLD_LOAD;
            end else if (cnt == '0) begin
                state        <= ST_PERIPH;
                cnt          <= STAGE_LOAD;
                periph_reset <= 1'b0;
            end else begin
                cnt <= cnt - CNT_ONE;
            end
        end else if (src) begin
            // A new source outranks every other transition outside HOLD.
            state        <= ST_HOLD;
            cnt          <= HOLD_LOAD;
            periph_reset <= 1'b1;
            mem_reset    <= 1'b1;
            cpu_resetn   <= 1'b0;
            sys_ready    <= 1'b0;
            reset_cause  <= src_bits;
        end else begin
            case (state)
                ST_PERIPH: begin
                    if (cnt == '0) begin
                        state     <= ST_MEM;
                        cnt       <= MEM_LOAD;
                        mem_reset <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_MEM: begin
                    // Done wins over a timeout expiring on the same edge.
                    if (mem_init_done) begin
                        state      <= ST_CPU;
                        cpu_resetn <= 1'b1;
                    end else if (cnt == '0) begin
                        state       <= ST_CPU;
                        cpu_resetn  <= 1'b1;
                        mem_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_CPU: begin
                    state     <= ST_RUN;
                    sys_ready <= 1'b1;
                end
                ST_RUN: begin
                    state <= ST_RUN;
                end
                default: begin
                    // Unused encodings fall back into a full reset hold.
                    state        <= ST_HOLD;
                    cnt          <= HOLD_LOAD;
                    periph_reset <= 1'b1;
                    mem_reset    <= 1'b1;
                    cpu_resetn   <= 1'b0;
                    sys_ready    <= 1'b0;
                end
            endcase
        end
    end

endmodule
